// File: rtl/defender_pkg.sv
// rtl/defender_pkg.sv - shared screen geometry, projectile slot type and hit-box helper
package defender_pkg;

    localparam int SCREEN_H     = 480;
    localparam int COORD_W      = 10;
    localparam int PLAYER_HIT_W = 10;
    localparam int PLAYER_HIT_H = 20;

    typedef logic [COORD_W-1:0] coord_t;

    typedef struct packed {
        logic   valid;
        coord_t x;
        coord_t y;
    } shot_t;

    // One extra bit keeps py + PLAYER_HIT_H from wrapping near the bottom of the coordinate range.
    function automatic logic in_hit_box(input coord_t sx, input coord_t sy,
                                        input coord_t px, input coord_t py);
        logic [COORD_W:0] dx;
        logic [COORD_W:0] y_end;
        dx    = (sx >= px) ? ({1'b0, sx} - {1'b0, px}) : ({1'b0, px} - {1'b0, sx});
        y_end = {1'b0, py} + (COORD_W+1)'(PLAYER_HIT_H);
        return (dx < (COORD_W+1)'(PLAYER_HIT_W)) && (sy >= py) && ({1'b0, sy} < y_end);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick, search starts at a pointer held by the parent
module rr_arbiter #(
    parameter int N = 4,
    parameter int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] gnt,
    output logic [W-1:0] winner,
    output logic         found
);

    logic [W-1:0] idx;

    always_comb begin
        gnt    = '0;
        winner = '0;
        found  = 1'b0;
        idx    = '0;
        for (int i = 0; i < N; i++) begin
            idx = W'((32'(ptr) + 32'(i)) % 32'(N));
            if (!found && req[idx]) begin
                found    = 1'b1;
                winner   = idx;
                gnt[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/enemy_fire_sched.sv
// rtl/enemy_fire_sched.sv - grants invader fire requests into a shared projectile slot pool
module enemy_fire_sched
    import defender_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int N_SLOT   = 2,
    parameter int COOLDOWN = 512,
    parameter int SPEED    = 2,
    parameter int Y_LIMIT  = SCREEN_H
) (
    input  logic                    dclk,
    input  logic                    clr,
    input  logic                    play,
    input  logic                    tick,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*10-1:0]     req_x,
    input  logic [N_REQ*10-1:0]     req_y,
    output logic [N_REQ-1:0]        gnt,
    input  logic [9:0]              player_x,
    input  logic [9:0]              player_y,
    output logic [N_SLOT-1:0]       shot_valid,
    output logic [N_SLOT*10-1:0]    shot_x,
    output logic [N_SLOT*10-1:0]    shot_y,
    output logic                    player_hit,
    output logic                    busy
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CD_W  = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;

    localparam logic [CD_W-1:0]  CD_RELOAD = CD_W'(COOLDOWN - 1);
    localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(N_REQ - 1);
    localparam coord_t           Y_LIM     = COORD_W'(Y_LIMIT);
    localparam coord_t           STEP_Y    = COORD_W'(SPEED);

    shot_t            slot_q [N_SLOT];
    shot_t            slot_d [N_SLOT];
    logic [CD_W-1:0]  cd_q, cd_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic             player_hit_q, player_hit_d;

    logic [N_SLOT-1:0] valid_vec;
    logic [N_SLOT-1:0] hit_vec;
    logic [N_REQ-1:0]  arb_gnt;
    logic [PTR_W-1:0]  winner;
    logic              arb_found;
    logic              arb_en;
    logic              grant;
    logic              loaded;
    coord_t            load_x;
    coord_t            load_y;

    always_comb begin
        valid_vec = '0;
        hit_vec   = '0;
        for (int s = 0; s < N_SLOT; s++) begin
            valid_vec[s] = slot_q[s].valid;
            hit_vec[s]   = slot_q[s].valid &&
                           in_hit_box(slot_q[s].x, slot_q[s].y, player_x, player_y);
        end
    end

    rr_arbiter #(
        .N (N_REQ),
        .W (PTR_W)
    ) u_arb (
        .req    (req),
        .ptr    (ptr_q),
        .gnt    (arb_gnt),
        .winner (winner),
        .found  (arb_found)
    );

    // Free-slot test uses registered valid, so a slot freed this cycle is only grantable next cycle.
    assign arb_en = tick & play & (cd_q == '0) & ~(&valid_vec);
    assign grant  = arb_en & arb_found;
    assign gnt    = arb_en ? arb_gnt : '0;

    always_comb begin
        load_x = '0;
        load_y = '0;
        for (int r = 0; r < N_REQ; r++) begin
            if (winner == PTR_W'(r)) begin
                load_x = req_x[r*COORD_W +: COORD_W];
                load_y = req_y[r*COORD_W +: COORD_W];
            end
        end
    end

    always_comb begin
        slot_d       = slot_q;
        cd_d         = cd_q;
        ptr_d        = ptr_q;
        player_hit_d = 1'b0;
        loaded       = 1'b0;
        if (!play) begin
            for (int s = 0; s < N_SLOT; s++) begin
                slot_d[s] = '0;
            end
            cd_d  = '0;
            ptr_d = '0;
        end else begin
            player_hit_d = |hit_vec;
            if (tick) begin
                if (grant) begin
                    cd_d  = CD_RELOAD;
                    ptr_d = (winner == PTR_LAST) ? '0 : winner + 1'b1;
                end else if (cd_q != '0) begin
                    cd_d = cd_q - 1'b1;
                end
            end
            // Hit beats movement; a freshly loaded slot does not move on its load tick.
            for (int s = 0; s < N_SLOT; s++) begin
                if (hit_vec[s]) begin
                    slot_d[s].valid = 1'b0;
                end else if (grant && !loaded && !slot_q[s].valid) begin
                    slot_d[s].valid = 1'b1;
                    slot_d[s].x     = load_x;
                    slot_d[s].y     = load_y;
                    loaded          = 1'b1;
                end else if (tick && slot_q[s].valid) begin
                    if (slot_q[s].y > Y_LIM) begin
                        slot_d[s].valid = 1'b0;
                        slot_d[s].y     = '0;
                    end else begin
                        slot_d[s].y = slot_q[s].y + STEP_Y;
                    end
                end
            end
        end
    end

    always_ff @(posedge dclk or posedge clr) begin
        if (clr) begin
            for (int s = 0; s < N_SLOT; s++) begin
                slot_q[s] <= '0;
            end
            cd_q         <= '0;
            ptr_q        <= '0;
            player_hit_q <= 1'b0;
        end else begin
            slot_q       <= slot_d;
            cd_q         <= cd_d;
            ptr_q        <= ptr_d;
            player_hit_q <= player_hit_d;
        end
    end

    always_comb begin
        shot_x = '0;
        shot_y = '0;
        for (int s = 0; s < N_SLOT; s++) begin
            shot_x[s*COORD_W +: COORD_W] = slot_q[s].x;
            shot_y[s*COORD_W +: COORD_W] = slot_q[s].y;
        end
    end

    assign shot_valid = valid_vec;
    assign busy       = &valid_vec;
    assign player_hit = player_hit_q;

endmodule

// File: tb/tb_enemy_fire_sched.sv
// tb/tb_enemy_fire_sched.sv - vector table, corner sequences and random run against a behavioural model
module tb_enemy_fire_sched;

    logic        dclk = 1'b0;
    logic        clr;
    logic        play;
    logic        tick;
    logic [3:0]  req;
    logic [9:0]  rx [4];
    logic [9:0]  ry [4];
    logic [39:0] req_x;
    logic [39:0] req_y;
    logic [9:0]  player_x;
    logic [9:0]  player_y;
    logic [3:0]  gnt_a, gnt_b;
    logic [1:0]  sv_a, sv_b;
    logic [19:0] sx_a, sy_a, sx_b, sy_b;
    logic        hit_a, hit_b, busy_a, busy_b;
    logic [3:0]  cap_gnt_a, cap_gnt_b;

    int total = 0;
    int bad   = 0;

    bit m_v   [2][2];
    int m_x   [2][2];
    int m_y   [2][2];
    int m_cd  [2];
    int m_ptr [2];
    bit m_hit [2];

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic [9:0] px;
        logic [9:0] py;
        logic       exp_hit;
    } hv_t;

    hv_t hv [10];
    int  gq [$];

    always #5 dclk = ~dclk;

    always_comb begin
        req_x = '0;
        req_y = '0;
        for (int r = 0; r < 4; r++) begin
            req_x[r*10 +: 10] = rx[r];
            req_y[r*10 +: 10] = ry[r];
        end
    end

    enemy_fire_sched #(.N_REQ(4), .N_SLOT(2), .COOLDOWN(1), .SPEED(2), .Y_LIMIT(480)) dut_a (
        .dclk(dclk), .clr(clr), .play(play), .tick(tick), .req(req),
        .req_x(req_x), .req_y(req_y), .gnt(gnt_a), .player_x(player_x), .player_y(player_y),
        .shot_valid(sv_a), .shot_x(sx_a), .shot_y(sy_a), .player_hit(hit_a), .busy(busy_a)
    );

    enemy_fire_sched #(.N_REQ(4), .N_SLOT(2), .COOLDOWN(4), .SPEED(2), .Y_LIMIT(480)) dut_b (
        .dclk(dclk), .clr(clr), .play(play), .tick(tick), .req(req),
        .req_x(req_x), .req_y(req_y), .gnt(gnt_b), .player_x(player_x), .player_y(player_y),
        .shot_valid(sv_b), .shot_x(sx_b), .shot_y(sy_b), .player_hit(hit_b), .busy(busy_b)
    );

    function automatic int cool_of(input int m);
        return (m == 0) ? 1 : 4;
    endfunction

    function automatic int m_winner(input int m);
        if (!play || !tick || m_cd[m] != 0 || (m_v[m][0] && m_v[m][1])) return -1;
        for (int k = 0; k < 4; k++) begin
            if (req[(m_ptr[m] + k) % 4]) return (m_ptr[m] + k) % 4;
        end
        return -1;
    endfunction

    function automatic bit m_hits(input int m, input int s);
        int dx;
        dx = m_x[m][s] - int'(player_x);
        if (dx < 0) dx = -dx;
        return m_v[m][s] && (dx < 10) && (m_y[m][s] >= int'(player_y)) &&
               (m_y[m][s] < int'(player_y) + 20);
    endfunction

    task automatic model_reset(input int m);
        for (int s = 0; s < 2; s++) begin
            m_v[m][s] = 1'b0;
            m_x[m][s] = 0;
            m_y[m][s] = 0;
        end
        m_cd[m]  = 0;
        m_ptr[m] = 0;
        m_hit[m] = 1'b0;
    endtask

    task automatic model_next(input int m);
        int w;
        bit h [2];
        bit placed;
        w      = m_winner(m);
        placed = 1'b0;
        for (int s = 0; s < 2; s++) h[s] = m_hits(m, s);
        if (!play) begin
            model_reset(m);
            return;
        end
        m_hit[m] = h[0] | h[1];
        for (int s = 0; s < 2; s++) begin
            if (h[s]) begin
                m_v[m][s] = 1'b0;
            end else if (w >= 0 && !placed && !m_v[m][s]) begin
                m_v[m][s] = 1'b1;
                m_x[m][s] = int'(rx[w]);
                m_y[m][s] = int'(ry[w]);
                placed    = 1'b1;
            end else if (tick && m_v[m][s]) begin
                if (m_y[m][s] > 480) begin
                    m_v[m][s] = 1'b0;
                    m_y[m][s] = 0;
                end else begin
                    m_y[m][s] = m_y[m][s] + 2;
                end
            end
        end
        if (tick) begin
            if (w >= 0) m_cd[m] = cool_of(m) - 1;
            else if (m_cd[m] > 0) m_cd[m] = m_cd[m] - 1;
        end
        if (w >= 0) m_ptr[m] = (w + 1) % 4;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_dut(input int m, input logic [3:0] g, input logic [1:0] sv,
                             input logic [19:0] sx, input logic [19:0] sy,
                             input logic h, input logic b);
        int    w;
        string tag;
        tag = (m == 0) ? "a" : "b";
        w   = m_winner(m);
        chk({"gnt_", tag}, int'(g), (w < 0) ? 0 : (1 << w));
        for (int s = 0; s < 2; s++) begin
            chk($sformatf("valid%0d_%s", s, tag), int'(sv[s]), int'(m_v[m][s]));
            chk($sformatf("x%0d_%s", s, tag), int'(sx[s*10 +: 10]), m_x[m][s]);
            chk($sformatf("y%0d_%s", s, tag), int'(sy[s*10 +: 10]), m_y[m][s]);
        end
        chk({"player_hit_", tag}, int'(h), int'(m_hit[m]));
        chk({"busy_", tag}, int'(b), int'(m_v[m][0] && m_v[m][1]));
    endtask

    // Called at a falling edge with inputs already applied; returns at the next falling edge.
    task automatic step();
        #1;
        cap_gnt_a = gnt_a;
        cap_gnt_b = gnt_b;
        check_dut(0, gnt_a, sv_a, sx_a, sy_a, hit_a, busy_a);
        check_dut(1, gnt_b, sv_b, sx_b, sy_b, hit_b, busy_b);
        model_next(0);
        model_next(1);
        @(negedge dclk);
    endtask

    task automatic clear_all();
        play = 1'b0;
        tick = 1'b0;
        req  = '0;
        step();
        play = 1'b1;
    endtask

    initial begin
        hv[0] = '{10'd105, 10'd300, 10'd100, 10'd295, 1'b1};
        hv[1] = '{10'd110, 10'd300, 10'd100, 10'd295, 1'b0};
        hv[2] = '{10'd91,  10'd300, 10'd100, 10'd295, 1'b1};
        hv[3] = '{10'd90,  10'd300, 10'd100, 10'd295, 1'b0};
        hv[4] = '{10'd100, 10'd295, 10'd100, 10'd295, 1'b1};
        hv[5] = '{10'd100, 10'd314, 10'd100, 10'd295, 1'b1};
        hv[6] = '{10'd100, 10'd315, 10'd100, 10'd295, 1'b0};
        hv[7] = '{10'd100, 10'd294, 10'd100, 10'd295, 1'b0};
        hv[8] = '{10'd3,   10'd1020, 10'd0,  10'd1010, 1'b1};
        hv[9] = '{10'd0,   10'd300, 10'd1023, 10'd295, 1'b0};

        clr = 1'b1; play = 1'b0; tick = 1'b0; req = '0;
        player_x = '0; player_y = 10'd1000;
        for (int r = 0; r < 4; r++) begin
            rx[r] = 10'(100 * (r + 1));
            ry[r] = 10'd50;
        end
        model_reset(0);
        model_reset(1);
        #2;
        chk("reset_valid", int'(sv_a), 0);
        chk("reset_gnt", int'(gnt_a), 0);
        chk("reset_hit", int'(hit_a), 0);
        chk("reset_y", int'(sy_a), 0);
        @(negedge dclk);
        clr = 1'b0;

        // geometry table: load one shot, then evaluate the hit box against it
        for (int i = 0; i < 10; i++) begin
            clear_all();
            rx[0] = hv[i].x; ry[0] = hv[i].y;
            player_x = hv[i].px; player_y = hv[i].py;
            req = 4'b0001; tick = 1'b1;
            step();
            req = '0; tick = 1'b0;
            step();
            chk($sformatf("hit_tbl%0d", i), int'(hit_a), int'(hv[i].exp_hit));
            chk($sformatf("hit_clear%0d", i), int'(sv_a[0]), int'(!hv[i].exp_hit));
        end
        player_x = '0; player_y = 10'd1000;
        for (int r = 0; r < 4; r++) begin
            rx[r] = 10'(100 * (r + 1));
            ry[r] = 10'd50;
        end

        // asynchronous clear with a shot in flight
        clear_all();
        ry[0] = 10'd100; req = 4'b0001; tick = 1'b1;
        step();
        req = '0; tick = 1'b0;
        step();
        chk("pre_clr_valid", int'(sv_a[0]), 1);
        #2 clr = 1'b1;
        #1;
        chk("clr_valid", int'(sv_a), 0);
        chk("clr_valid_b", int'(sv_b), 0);
        chk("clr_y", int'(sy_a), 0);
        chk("clr_gnt", int'(gnt_a), 0);
        chk("clr_hit", int'(hit_a), 0);
        model_reset(0);
        model_reset(1);
        @(negedge dclk);
        clr = 1'b0;
        ry[0] = 10'd50;

        // round robin with all requests held
        clear_all();
        req = 4'b1111; tick = 1'b1;
        step(); chk("rr_g0", int'(cap_gnt_a), 4'b0001);
        step(); chk("rr_g1", int'(cap_gnt_a), 4'b0010);
        step(); chk("rr_full", int'(cap_gnt_a), 0);
        chk("rr_busy", int'(busy_a), 1);
        tick = 1'b0; player_x = 10'd100; player_y = 10'd45;
        step();
        chk("rr_hit", int'(hit_a), 1);
        chk("rr_freed", int'(sv_a[0]), 0);
        player_x = '0; player_y = 10'd1000; tick = 1'b1;
        step();
        chk("rr_next", int'(cap_gnt_a), 4'b0100);
        chk("rr_hit_once", int'(hit_a), 0);

        // cooldown spacing on the COOLDOWN=4 instance
        clear_all();
        req = 4'b0001; tick = 1'b1;
        gq.delete();
        for (int k = 0; k < 12; k++) begin
            step();
            if (cap_gnt_b[0]) gq.push_back(k);
        end
        chk("cd_count", gq.size(), 2);
        if (gq.size() == 2) begin
            chk("cd_first", gq[0], 0);
            chk("cd_gap", gq[1] - gq[0], 4);
        end

        // retire past the bottom
        clear_all();
        ry[0] = 10'd479; req = 4'b0001; tick = 1'b1;
        step();
        req = '0;
        step();
        chk("ret_y481", int'(sy_a[9:0]), 481);
        chk("ret_live", int'(sv_a[0]), 1);
        step();
        chk("ret_valid", int'(sv_a[0]), 0);
        chk("ret_y0", int'(sy_a[9:0]), 0);
        chk("ret_nohit", int'(hit_a), 0);
        ry[0] = 10'd50;

        // hit and request collide while the pool is full
        clear_all();
        rx[0] = 10'd100; rx[1] = 10'd300; rx[2] = 10'd500; rx[3] = 10'd700;
        req = 4'b0001; tick = 1'b1;
        step();
        req = 4'b0010;
        step();
        req = 4'b0100; player_x = 10'd300; player_y = 10'd45;
        step();
        chk("sim_nognt", int'(cap_gnt_a), 0);
        chk("sim_hit", int'(hit_a), 1);
        player_y = 10'd1000;
        step();
        chk("sim_gnt2", int'(cap_gnt_a), 4'b0100);
        chk("sim_reload_x", int'(sx_a[19:10]), 500);
        chk("sim_full", int'(sv_a), 3);

        // random run
        clear_all();
        for (int n = 0; n < 2000; n++) begin
            play = ($urandom_range(0, 39) != 0);
            tick = ($urandom_range(0, 2) == 0);
            req  = 4'($urandom_range(0, 15));
            for (int r = 0; r < 4; r++) begin
                rx[r] = 10'($urandom_range(80, 140));
                ry[r] = 10'($urandom_range(200, 480));
            end
            player_x = 10'($urandom_range(90, 130));
            player_y = 10'($urandom_range(200, 480));
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
